// File: rtl/alarm_pattern_gen_if.sv
// rtl/alarm_pattern_gen_if.sv - control and indicator signals of the alarm pattern generator
interface alarm_pattern_gen_if #(
  parameter int STEPS = 12
);
  localparam int SIW = $clog2(STEPS);

  logic           start;
  logic           stop;
  logic           snooze;
  logic           light;
  logic           active;
  logic           done;
  logic [SIW-1:0] step_idx;

  // nap-timer control side
  modport master (
    output start, stop, snooze,
    input  light, active, done, step_idx
  );

  // sequencer side
  modport slave (
    input  start, stop, snooze,
    output light, active, done, step_idx
  );
endinterface

// File: rtl/alarm_pattern_gen.sv
// rtl/alarm_pattern_gen.sv - programmable on/off alarm light sequencer with snooze and repeat limit
module alarm_pattern_gen #(
  parameter int               STEPS        = 12,
  parameter logic [STEPS-1:0] PATTERN      = 12'h249,
  parameter int               PRESCALE     = 4,
  parameter int               REPEATS      = 2,
  parameter int               SNOOZE_STEPS = 3
) (
  input logic                clock,
  input logic                reset,
  alarm_pattern_gen_if.slave ctl
);

  localparam int SIW       = $clog2(STEPS);
  localparam int TW        = $clog2(PRESCALE + 1);
  localparam int RW        = (REPEATS == 0) ? 1 : $clog2(REPEATS + 1);
  localparam int SNZ_TOTAL = SNOOZE_STEPS * PRESCALE;
  localparam int SW        = $clog2(SNZ_TOTAL + 1);
  localparam int REP_LAST  = (REPEATS == 0) ? 0 : REPEATS - 1;

  localparam logic [SIW-1:0] STEP_LAST = SIW'(STEPS - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(PRESCALE - 1);
  localparam logic [RW-1:0]  REP_END   = RW'(REP_LAST);
  localparam logic [SW-1:0]  SNZ_LOAD  = SW'(SNZ_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SNOOZE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         r_state;
  logic [SIW-1:0] r_step;
  logic [TW-1:0]  r_tick;
  logic [RW-1:0]  r_rep;
  logic [SW-1:0]  r_snz;
  logic           r_light;
  logic           r_active;
  logic           r_done;

  logic [SIW-1:0] w_step_next;
  logic           w_tick_last;
  logic           w_step_last;
  logic           w_rep_last;

  assign w_step_next = r_step + 1'b1;
  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_step_last = (r_step == STEP_LAST);
  // with REPEATS==0 the sequence never finishes on its own
  assign w_rep_last  = (REPEATS != 0) && (r_rep == REP_END);

  // sequencer state, counters and registered indicator outputs; stop > snooze > start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_tick   <= '0;
      r_rep    <= '0;
      r_snz    <= '0;
      r_light  <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else if (ctl.stop) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_tick   <= '0;
      r_rep    <= '0;
      r_snz    <= '0;
      r_light  <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctl.start) begin
            r_state  <= S_RUN;
            r_step   <= '0;
            r_tick   <= '0;
            r_rep    <= '0;
            r_light  <= PATTERN[0];
            r_active <= 1'b1;
          end
        end
        S_RUN: begin
          if (ctl.snooze) begin
            // step is frozen here; the pattern restarts from slot 0 afterwards
            r_state <= S_SNOOZE;
            r_tick  <= '0;
            r_snz   <= SNZ_LOAD;
            r_light <= 1'b0;
          end else if (w_tick_last) begin
            r_tick <= '0;
            if (w_step_last) begin
              r_step <= '0;
              if (w_rep_last) begin
                r_state  <= S_DONE;
                r_rep    <= '0;
                r_light  <= 1'b0;
                r_active <= 1'b0;
                r_done   <= 1'b1;
              end else begin
                if (REPEATS != 0) begin
                  r_rep <= r_rep + 1'b1;
                end
                r_light <= PATTERN[0];
              end
            end else begin
              r_step  <= w_step_next;
              r_light <= PATTERN[w_step_next];
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_SNOOZE: begin
          if (r_snz == '0) begin
            // rep is kept so cycles finished before the snooze still count
            r_state <= S_RUN;
            r_step  <= '0;
            r_tick  <= '0;
            r_light <= PATTERN[0];
          end else begin
            r_snz <= r_snz - 1'b1;
          end
        end
        S_DONE: begin
          if (ctl.start) begin
            r_state  <= S_RUN;
            r_step   <= '0;
            r_tick   <= '0;
            r_rep    <= '0;
            r_light  <= PATTERN[0];
            r_active <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_light  <= 1'b0;
          r_active <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.light    = r_light;
  assign ctl.active   = r_active;
  assign ctl.done     = r_done;
  assign ctl.step_idx = r_step;

endmodule

// File: tb/tb_alarm_pattern_gen.sv
// tb/tb_alarm_pattern_gen.sv - scoreboard bench for alarm_pattern_gen in two configurations
module tb_alarm_pattern_gen;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  alarm_pattern_gen_if #(.STEPS(12)) a_if ();
  alarm_pattern_gen_if #(.STEPS(4))  b_if ();

  alarm_pattern_gen #(
    .STEPS(12), .PATTERN(12'h249), .PRESCALE(4), .REPEATS(2), .SNOOZE_STEPS(3)
  ) u_a (
    .clock(clock), .reset(reset), .ctl(a_if.slave)
  );

  alarm_pattern_gen #(
    .STEPS(4), .PATTERN(4'b0101), .PRESCALE(1), .REPEATS(0), .SNOOZE_STEPS(2)
  ) u_b (
    .clock(clock), .reset(reset), .ctl(b_if.slave)
  );

  // model: st 0 idle, 1 run, 2 snooze, 3 done; pos = clocks since the run began at slot 0
  typedef struct {
    int st;
    int pos;
    int rep_base;
    int left;
    int frozen;
  } mdl_t;

  typedef struct {
    bit light;
    bit active;
    bit done;
    int step;
    bit chk_step;
  } exp_t;

  int checks = 0;
  int errors = 0;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic mdl_t mdl_clear();
    mdl_t m;
    m.st = 0; m.pos = 0; m.rep_base = 0; m.left = 0; m.frozen = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input bit st, input bit sp, input bit sz,
                                    input int S, input int P, input int R, input int SN);
    mdl_t n = m;
    if (sp) begin
      n = mdl_clear();
    end else begin
      case (m.st)
        0, 3: if (st) begin n.st = 1; n.pos = 0; n.rep_base = 0; end
        1: begin
          if (sz) begin
            n.rep_base = m.rep_base + m.pos / (P * S);
            n.frozen   = (m.pos / P) % S;
            n.left     = SN * P;
            n.st       = 2;
          end else begin
            n.pos = m.pos + 1;
            if (R != 0 && n.rep_base + n.pos / (P * S) >= R) n.st = 3;
          end
        end
        2: begin
          n.left = m.left - 1;
          if (n.left == 0) begin n.st = 1; n.pos = 0; end
        end
        default: n = mdl_clear();
      endcase
    end
    return n;
  endfunction

  function automatic exp_t mdl_out(input mdl_t m, input int S, input int P, input logic [63:0] pat);
    exp_t e;
    int slot;
    slot       = (m.pos / P) % S;
    e.light    = (m.st == 1) ? pat[slot] : 1'b0;
    e.active   = (m.st == 1) || (m.st == 2);
    e.done     = (m.st == 3);
    e.step     = (m.st == 1) ? slot : ((m.st == 2) ? m.frozen : 0);
    e.chk_step = (m.st != 2);
    return e;
  endfunction

  logic [63:0] pat_a = 64'h249;
  logic [63:0] pat_b = 64'h5;

  // one clock of stimulus; expected response for the following edge goes to the scoreboard
  task automatic cyc(input bit st, input bit sp, input bit sz, input bit bst, input bit bsp, input bit bsz);
    @(negedge clock);
    reset       = 1'b1;
    a_if.start  = st;  a_if.stop = sp;  a_if.snooze = sz;
    b_if.start  = bst; b_if.stop = bsp; b_if.snooze = bsz;
    ma = mdl_next(ma, st, sp, sz, 12, 4, 2, 3);
    mb = mdl_next(mb, bst, bsp, bsz, 4, 1, 0, 2);
    qa.push_back(mdl_out(ma, 12, 4, pat_a));
    qb.push_back(mdl_out(mb, 4, 1, pat_b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // advance until A's model is running in the given slot at the given tick
  task automatic wait_a(input int slot, input int tk);
    int k = 0;
    while (!(ma.st == 1 && (ma.pos / 4) % 12 == slot && ma.pos % 4 == tk) && k < 500) begin
      cyc(0, 0, 0, 0, 0, 0);
      k++;
    end
    chk("wait_a_reached", (k < 500) ? 1 : 0, 1);
  endtask

  task automatic reset_now();
    @(negedge clock);
    #2;
    reset = 1'b0;
    a_if.start = 0; a_if.stop = 0; a_if.snooze = 0;
    b_if.start = 0; b_if.stop = 0; b_if.snooze = 0;
    #1;
    chk("async_rst_a_light",  a_if.light,    0);
    chk("async_rst_a_active", a_if.active,   0);
    chk("async_rst_a_done",   a_if.done,     0);
    chk("async_rst_a_step",   a_if.step_idx, 0);
    chk("async_rst_b_active", b_if.active,   0);
    ma = mdl_clear();
    mb = mdl_clear();
    qa.push_back(mdl_out(ma, 12, 4, pat_a));
    qb.push_back(mdl_out(mb, 4, 1, pat_b));
  endtask

  // scoreboard monitor: pops one expectation per edge and compares against the DUT outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a.light",  a_if.light,  e.light);
        chk("a.active", a_if.active, e.active);
        chk("a.done",   a_if.done,   e.done);
        if (e.chk_step) chk("a.step_idx", a_if.step_idx, e.step);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b.light",  b_if.light,  e.light);
        chk("b.active", b_if.active, e.active);
        chk("b.done",   b_if.done,   e.done);
        if (e.chk_step) chk("b.step_idx", b_if.step_idx, e.step);
      end
    end
  end

  initial begin
    reset = 1'b0;
    a_if.start = 0; a_if.stop = 0; a_if.snooze = 0;
    b_if.start = 0; b_if.stop = 0; b_if.snooze = 0;
    ma = mdl_clear();
    mb = mdl_clear();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      qa.push_back(mdl_out(ma, 12, 4, pat_a));
      qb.push_back(mdl_out(mb, 4, 1, pat_b));
    end
    idle(2);

    // full run to completion; B toggles indefinitely with no repeat limit
    cyc(1, 0, 0, 1, 0, 0);
    idle(100);
    // restart from DONE, snooze at slot 5, run to completion, stop in DONE
    cyc(1, 0, 0, 0, 0, 0);
    wait_a(5, 1);
    cyc(0, 0, 1, 0, 0, 0);
    idle(150);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);
    // stop during snooze
    cyc(1, 0, 0, 0, 0, 0);
    idle(6);
    cyc(0, 0, 1, 0, 0, 0);
    idle(4);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);
    // stop together with start in IDLE stays IDLE
    cyc(1, 1, 0, 0, 0, 0);
    idle(2);
    // snooze on a slot advance edge, then on the edge that would finish
    cyc(1, 0, 0, 0, 0, 0);
    wait_a(2, 3);
    cyc(0, 0, 1, 0, 0, 0);
    idle(30);
    wait_a(11, 3);
    wait_a(11, 3);
    cyc(0, 0, 1, 0, 0, 0);
    idle(120);
    // asynchronous reset mid-slot at step 7
    cyc(1, 0, 0, 0, 0, 0);
    wait_a(7, 2);
    reset_now();
    idle(5);

    // randomized control traffic on both instances
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 10) == 0, ($urandom % 60) == 0, ($urandom % 40) == 0,
          ($urandom % 10) == 0, ($urandom % 80) == 0, ($urandom % 30) == 0);
    end

    @(posedge clock);
    #2;
    chk("scoreboard_a_drained", qa.size(), 0);
    chk("scoreboard_b_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
